dbg_scan_ctrl: RTL and testbench
================================

// Module: dbg_scan_ctrl
// PURPOSE
//  Sequencer for the debug bus: given a start address and word count, walks chk_addr across
//  the debug map (CPU probes, RF, IMU, DMU regions) and streams each chk_data word out on a
//  valid/ready interface for the UART/display host. Sits between the debug host logic and the
//  debug mux; replaces manual single-address probing with burst dumps.
// PARAMETERS
//  RD_LAT  1   cycles between chk_addr change and chk_data valid (0 = pure combinational mux)
//  CNT_W   16  width of word-count request
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request pulse; sampled only in IDLE
//  base_addr  in   32     first debug address of burst
//  count      in   CNT_W  number of words to read (0 legal)
//  abort      in   1      terminate burst; higher priority than all else except rst
//  chk_addr   out  32     address to debug mux
//  chk_data   in   32     data from debug mux
//  out_data   out  32     streamed word
//  out_valid  out  1      out_data valid; held with stable data until out_ready
//  out_ready  in   1      host accepts word when out_valid & out_ready at clk edge
//  busy       out  1      burst in progress (not IDLE)
//  done       out  1      one-cycle pulse on normal completion
// BEHAVIOUR
//  Reset: chk_addr=0, out_data=0, out_valid=0, busy=0, done=0, state=IDLE, remaining=0.
//  FSM: IDLE -> ADDR -> WAIT (RD_LAT cycles, skipped if RD_LAT=0) -> PUSH -> ADDR|FIN; FIN -> IDLE.
//  IDLE: start=1 at edge E -> chk_addr<=base_addr, remaining<=count, busy=1 from E.
//   count=0 -> go to FIN (done pulses cycle after E, no words streamed).
//  ADDR: 1 cycle, chk_addr stable. Last of ADDR/WAIT cycles: out_data<=chk_data, out_valid<=1.
//  PUSH: hold out_valid/out_data until out_valid&out_ready edge; then remaining-1;
//   remaining becomes 0 -> FIN; else chk_addr<=chk_addr+1 (mod 2^32, 0xFFFFFFFF wraps to 0) -> ADDR.
//  FIN: done=1 for exactly one cycle, busy=1 during FIN; next cycle IDLE, busy=0.
//  Latency: first out_valid at E+RD_LAT+1; peak throughput one word per RD_LAT+2 cycles.
//  chk_addr never changes while out_valid=1 or during WAIT.
//  start while busy: ignored, no queueing. start and abort same cycle in IDLE: abort wins.
//  abort=1 in any non-IDLE state: next edge -> IDLE, out_valid=0, busy=0, done NOT pulsed;
//   a word accepted in the same cycle as abort counts as delivered; chk_addr retains value.
//  rst mid-burst: all outputs to reset values at that edge, burst discarded.
//  out_ready ignored when out_valid=0.
// CONFIGURATION
//  DBG_SCAN_CSUM_EN defined: after last data word, one extra word = 32-bit sum (mod 2^32) of
//   all streamed words, sent via PUSH with same handshake, then FIN; count=0 emits checksum 0.
//   Aborted bursts emit no checksum.
//  Undefined: no checksum state or adder; FIN follows last data word directly.
// STRUCTURE
//  dbg_pkg: FSM state enum (IDLE, ADDR, WAIT, PUSH, CSUM, FIN), debug region constants
//   (CPU=4'h0, RF=4'h1, IMU_USR=4'h2, IMU_INT=4'h3, DMU_USR=4'h4, DMU_STK=4'h5 at addr[19:16]).
//  Sub-module dbg_word_buf: single 32-bit output holding register with load/valid/ready logic.
// TESTING
//  RD_LAT=1, base=0x00010000, count=4, out_ready=1, RF model x1..x4=1..4 -> words 1,2,3,4 at
//   cycles E+2, E+5, E+8, E+11; done at E+12; chk_addr 0x10000..0x10003.
//  count=0 start -> no out_valid; done pulses at E+1; busy high E..E+1 only.
//  Backpressure: out_ready low 5 cycles on word 2 -> out_data/out_valid/chk_addr stable throughout,
//   word order unchanged.
//  base=0xFFFFFFFF, count=2 -> chk_addr 0xFFFFFFFF then 0x00000000.
//  abort during WAIT of word 3 of 8 -> IDLE next cycle, out_valid=0, no done; new start accepted.
//  DBG_SCAN_CSUM_EN, words 0x80000000,0x80000001 -> third word 0x00000001, then done.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared types and debug-map constants for the debug scan sequencer.
// Optional checksum word is enabled by defining DBG_SCAN_CSUM_EN.
package dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        PUSH,
        CSUM,
        FIN
    } scan_state_t;

    // Debug map regions, decoded from addr[19:16]
    localparam int          REGION_LSB = 16;
    localparam logic [3:0]  REG_CPU     = 4'h0;
    localparam logic [3:0]  REG_RF      = 4'h1;
    localparam logic [3:0]  REG_IMU_USR = 4'h2;
    localparam logic [3:0]  REG_IMU_INT = 4'h3;
    localparam logic [3:0]  REG_DMU_USR = 4'h4;
    localparam logic [3:0]  REG_DMU_STK = 4'h5;

    function automatic logic [3:0] dbg_region(input logic [31:0] addr);
        return addr[REGION_LSB+3:REGION_LSB];
    endfunction

endpackage

// File: rtl/dbg_word_buf.sv
// Single-entry output holding register: captures a word on load and holds it
// with valid asserted until the host handshakes it.
module dbg_word_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        accept
);

    logic [31:0] data_reg;
    logic        valid_reg;

    assign accept    = valid_reg & out_ready;
    assign out_data  = data_reg;
    assign out_valid = valid_reg;

    // Data is kept on clear so an aborted burst leaves the last word visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (clr) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            data_reg  <= load_data;
            valid_reg <= 1'b1;
        end else if (accept) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/dbg_scan_ctrl.sv
// Burst sequencer for the debug bus: walks chk_addr and streams chk_data words
// on a valid/ready port. Define DBG_SCAN_CSUM_EN to append a 32-bit sum word.
module dbg_scan_ctrl
    import dbg_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic [31:0]      chk_addr,
    input  logic [31:0]      chk_data,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

`ifdef DBG_SCAN_CSUM_EN
    localparam scan_state_t TAIL_ST = CSUM;
`else
    localparam scan_state_t TAIL_ST = FIN;
`endif

    scan_state_t       state_reg, state_next;
    logic [31:0]       chk_addr_reg, chk_addr_next;
    logic [CNT_W-1:0]  remaining_reg, remaining_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              buf_load, buf_clr, buf_accept;
    logic [31:0]       buf_load_data;
`ifdef DBG_SCAN_CSUM_EN
    logic [31:0]       sum_reg, sum_next;
    logic              csum_sent_reg, csum_sent_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            chk_addr_reg  <= '0;
            remaining_reg <= '0;
            wait_cnt_reg  <= '0;
`ifdef DBG_SCAN_CSUM_EN
            sum_reg       <= '0;
            csum_sent_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            chk_addr_reg  <= chk_addr_next;
            remaining_reg <= remaining_next;
            wait_cnt_reg  <= wait_cnt_next;
`ifdef DBG_SCAN_CSUM_EN
            sum_reg       <= sum_next;
            csum_sent_reg <= csum_sent_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        chk_addr_next  = chk_addr_reg;
        remaining_next = remaining_reg;
        wait_cnt_next  = wait_cnt_reg;
        buf_load       = 1'b0;
        buf_clr        = 1'b0;
        buf_load_data  = chk_data;
`ifdef DBG_SCAN_CSUM_EN
        sum_next       = sum_reg;
        csum_sent_next = csum_sent_reg;
`endif
        // Abort outranks everything; chk_addr is deliberately left where it was.
        if (abort && state_reg != IDLE) begin
            state_next = IDLE;
            buf_clr    = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        chk_addr_next  = base_addr;
                        remaining_next = count;
                        state_next     = (count == '0) ? TAIL_ST : ADDR;
`ifdef DBG_SCAN_CSUM_EN
                        sum_next       = '0;
                        csum_sent_next = 1'b0;
`endif
                    end
                end
                ADDR: begin
                    if (RD_LAT == 0) begin
                        buf_load   = 1'b1;
                        state_next = PUSH;
                    end else begin
                        wait_cnt_next = '0;
                        state_next    = WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_reg == WAIT_LAST) begin
                        buf_load   = 1'b1;
                        state_next = PUSH;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 1'b1;
                    end
                end
                PUSH: begin
                    if (buf_accept) begin
`ifdef DBG_SCAN_CSUM_EN
                        if (csum_sent_reg) state_next = FIN;
                        else
`endif
                        begin
                            remaining_next = remaining_reg - 1'b1;
                            if (remaining_reg == CNT_W'(1)) begin
                                state_next = TAIL_ST;
                            end else begin
                                chk_addr_next = chk_addr_reg + 32'd1;
                                state_next    = ADDR;
                            end
                        end
                    end
                end
`ifdef DBG_SCAN_CSUM_EN
                CSUM: begin
                    buf_load       = 1'b1;
                    buf_load_data  = sum_reg;
                    csum_sent_next = 1'b1;
                    state_next     = PUSH;
                end
`endif
                FIN:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
`ifdef DBG_SCAN_CSUM_EN
            // Sum what gets loaded; an aborted burst never reaches CSUM anyway.
            if (buf_load && state_reg != CSUM) sum_next = sum_reg + chk_data;
`endif
        end
    end

    dbg_word_buf u_word_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (buf_clr),
        .load      (buf_load),
        .load_data (buf_load_data),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .accept    (buf_accept)
    );

    assign chk_addr = chk_addr_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == FIN);

endmodule

// File: tb/tb_dbg_scan_ctrl.sv
// Scoreboard bench for dbg_scan_ctrl: stimulus queues expected words from a
// debug-map model, a negedge monitor pops and compares on every handshake.
module tb_dbg_scan_ctrl;

    localparam int CNT_W = 16;
`ifdef DBG_SCAN_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic             clk = 1'b0;
    logic             rst, start, abort;
    logic [31:0]      base_addr, chk_addr, chk_data, out_data;
    logic [CNT_W-1:0] count;
    logic             out_valid, busy, done;
    logic             out_ready = 1'b1;

    dbg_scan_ctrl #(.RD_LAT(1), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .abort     (abort),
        .chk_addr  (chk_addr),
        .chk_data  (chk_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Debug map contents: RF window holds x1..xN = 1..N, a second window holds
    // 0x80000000+k, everything else is a scrambled function of the address.
    function automatic logic [31:0] mux_fn(input logic [31:0] a);
        if (a[31:16] == 16'h0001) return {16'h0, a[15:0]} + 32'd1;
        if (a[31:16] == 16'h0002) return 32'h8000_0000 + {16'h0, a[15:0]};
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // One-cycle registered debug mux
    always @(posedge clk) chk_data <= mux_fn(chk_addr);

    int   ready_mode  = 0;
    logic ready_force = 1'b1;
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = ready_force;
        endcase
    end

    int test_cnt = 0, fail_cnt = 0;
    int done_cnt = 0, done_cyc = -1, stall_cnt = 0, word_no = 0;
    logic [31:0] exp_q[$];
    int          acc_cyc_q[$];
    logic [31:0] acc_addr_q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s actual=%h expected=%h (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [31:0] prev_d = '0, prev_a = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_data", out_data, prev_d);
                chk("hold_addr", chk_addr, prev_a);
            end
            if (out_valid && !out_ready) stall_cnt++;
            if (out_valid && out_ready) begin
                word_no++;
                if (exp_q.size() == 0) begin
                    test_cnt++;
                    fail_cnt++;
                    $display("[TB] FAIL unexpected_word actual=%h expected=none (cyc %0d)", out_data, cyc);
                end else begin
                    chk("word", out_data, exp_q.pop_front());
                end
                acc_cyc_q.push_back(cyc);
                acc_addr_q.push_back(chk_addr);
                $display("[TB] word %0d cyc=%0d addr=%h data=%h", word_no, cyc, chk_addr, out_data);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_v = out_valid;
            prev_r = out_ready;
            prev_d = out_data;
            prev_a = chk_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queues the words the host should see; the checksum only follows a full burst.
    task automatic start_burst(input logic [31:0] b, input logic [CNT_W-1:0] c,
                               input int n_exp, output int e);
        logic [31:0] s, w;
        s = '0;
        for (int i = 0; i < n_exp; i++) begin
            w = mux_fn(b + 32'(i));
            exp_q.push_back(w);
            s = s + w;
        end
`ifdef DBG_SCAN_CSUM_EN
        if (n_exp == int'(c)) exp_q.push_back(s);
`endif
        base_addr = b;
        count     = c;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        e         = cyc;
        $display("[TB] start cyc=%0d base=%h count=%0d", e, b, c);
    endtask

    task automatic finish_burst(input string name, input int done_before, input bit noise);
        int t;
        t = 0;
        while (done_cnt == done_before && t < 3000) begin
            if (noise) begin
                start     = ($urandom_range(0, 3) == 0);
                base_addr = $urandom;
                count     = CNT_W'($urandom_range(1, 5));
            end
            tick();
            t++;
        end
        start = 1'b0;
        chk({name, "_done"}, done_cnt, done_before + 1);
        chk({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int e, db;
        logic [31:0] b;
        logic [CNT_W-1:0] c;

        rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; count = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_chk_addr", chk_addr, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic RF dump: timing, addresses and data
        acc_cyc_q.delete(); acc_addr_q.delete();
        db = done_cnt;
        start_burst(32'h0001_0000, 16'd4, 4, e);
        finish_burst("basic", db, 1'b0);
        chk("basic_nwords", acc_cyc_q.size(), 4 + CS);
        for (int i = 0; i < 4 && i < acc_cyc_q.size(); i++) begin
            chk("basic_word_cyc", acc_cyc_q[i], e + 2 + 3 * i);
            chk("basic_word_addr", acc_addr_q[i], 32'h0001_0000 + 32'(i));
        end
        chk("basic_done_cyc", done_cyc, e + 12 + 2 * CS);

        // Zero-length burst
        db = done_cnt;
        start_burst(32'h0001_0000, 16'd0, 0, e);
        @(negedge clk);
        chk("zero_busy_e", {31'b0, busy}, 32'd1);
`ifndef DBG_SCAN_CSUM_EN
        chk("zero_done_e", {31'b0, done}, 32'd1);
`endif
        finish_burst("zero", db, 1'b0);
        chk("zero_done_cyc", done_cyc, e + 2 * CS);
        @(negedge clk);
        chk("zero_busy_after", {31'b0, busy}, 32'd0);

        // Backpressure on word 2 for five cycles
        ready_mode = 2; ready_force = 1'b1; stall_cnt = 0;
        db = done_cnt;
        start_burst(32'h0001_0010, 16'd4, 4, e);
        while (cyc < e + 5) tick();
        ready_force = 1'b0;
        while (cyc < e + 10) tick();
        ready_force = 1'b1;
        finish_burst("bp", db, 1'b0);
        chk("bp_stalls", stall_cnt, 5);
        ready_mode = 0;

        // Address wrap
        acc_cyc_q.delete(); acc_addr_q.delete();
        db = done_cnt;
        start_burst(32'hFFFF_FFFF, 16'd2, 2, e);
        finish_burst("wrap", db, 1'b0);
        chk("wrap_nwords", acc_addr_q.size(), 2 + CS);
        if (acc_addr_q.size() >= 2) begin
            chk("wrap_addr0", acc_addr_q[0], 32'hFFFF_FFFF);
            chk("wrap_addr1", acc_addr_q[1], 32'h0000_0000);
        end

        // Abort during WAIT of word 3 of 8
        db = done_cnt;
        start_burst(32'h0001_0020, 16'd8, 2, e);
        while (cyc < e + 7) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_addr", chk_addr, 32'h0001_0022);
        repeat (4) tick();
        chk("abort_no_done", done_cnt, db);
        chk("abort_drain", exp_q.size(), 0);
        exp_q.delete();

        // Start and abort together in IDLE: abort wins
        abort = 1'b1; start = 1'b1; base_addr = 32'h0001_0000; count = 16'd3;
        tick();
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", {31'b0, busy}, 32'd0);
        repeat (3) tick();
        chk("idle_abort_no_done", done_cnt, db);

        // New burst after abort, then checksum pattern
        db = done_cnt;
        start_burst(32'h0001_0000, 16'd3, 3, e);
        finish_burst("post_abort", db, 1'b0);
        db = done_cnt;
        start_burst(32'h0002_0000, 16'd2, 2, e);
        finish_burst("csum_pat", db, 1'b0);

        // Randomized bursts with random backpressure and ignored starts
        ready_mode = 1;
        for (int n = 0; n < 25; n++) begin
            b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
            c = CNT_W'($urandom_range(0, 6));
            db = done_cnt;
            start_burst(b, c, int'(c), e);
            finish_burst("rnd", db, 1'b1);
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
